dest_reg_pipe: RTL and testbench

DEST_REG_PIPE -- requirements
Module: dest_reg_pipe

---
 rtl/dest_reg_pipe.sv | 108 ++++++++++
 tb/tb_dest_reg_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dest_reg_pipe.sv
// dest_reg_pipe
//   Carries the destination register address and write enable of each decoded
//   instruction down a STAGES-deep pipeline to writeback. It also reports, per
//   stage, whether an in-flight write targets either decode-stage source
//   register, so that hazard logic can stall or forward.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   in_valid, reg_write decode instruction present / writes the register file
//   sel                 destination select: 00 rt, 01 rd, 10/11 LINK_REG (11 flagged)
//   rt_addr, rd_addr    candidate destination addresses
//   stall, flush        freeze the pipeline / invalidate every in-flight entry
//   src_a, src_b        decode-stage source addresses for the hazard compare
//   out_dst, out_we     writeback destination and write enable (last stage)
//   hit_a, hit_b        per-stage source match, bit 0 = youngest stage
//   hazard              stage-0 match on either source
//   sel_err             registered illegal-select flag
module dest_reg_pipe #(
  parameter int ADDR_W   = 5,
  parameter int STAGES   = 3,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              reg_write,
  input  logic [1:0]        sel,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  output logic [ADDR_W-1:0] out_dst,
  output logic              out_we,
  output logic [STAGES-1:0] hit_a,
  output logic [STAGES-1:0] hit_b,
  output logic              hazard,
  output logic              sel_err
);

  localparam logic [ADDR_W-1:0] LINK = ADDR_W'(LINK_REG);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] we_q;
  logic [ADDR_W-1:0] dst_q [STAGES];

  logic [ADDR_W-1:0] cap_dst;
  logic              cap_we;

  // Destination select; the illegal encoding still targets the link register
  // so the instruction behaves like a JAL while sel_err reports the fault.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    cap_dst = LINK;
    case (sel)
      2'b00:   cap_dst = rt_addr;
      2'b01:   cap_dst = rd_addr;
      default: cap_dst = LINK;
    endcase
  end

  // Register 0 is hard-wired to zero, so writes to it are never issued.
  assign cap_we = in_valid & reg_write & (cap_dst != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      we_q    <= '0;
      sel_err <= 1'b0;
      // NOTE: the dst array is small and is observable on out_dst right after
      // reset, so it is cleared here rather than left to hold stale values.
      for (int i = 0; i < STAGES; i++) dst_q[i] <= '0;
    end else if (flush) begin
      // Only the qualifying bits are cleared; dst fields are don't-care.
      valid_q <= '0;
      we_q    <= '0;
    end else if (!stall) begin
      // NOTE: non-blocking assignments let every stage read its predecessor's
      // old value, so the loop order does not matter.
      for (int i = STAGES - 1; i > 0; i--) begin
        valid_q[i] <= valid_q[i-1];
        we_q[i]    <= we_q[i-1];
        dst_q[i]   <= dst_q[i-1];
      end
      valid_q[0] <= in_valid;
      we_q[0]    <= cap_we;
      dst_q[0]   <= cap_dst;
      sel_err    <= in_valid & (sel == 2'b11);
    end
  end

  assign out_dst = dst_q[STAGES-1];
  assign out_we  = valid_q[STAGES-1] & we_q[STAGES-1];

  // A zero source never creates a dependency, since r0 is never written.
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int i = 0; i < STAGES; i++) begin
      hit_a[i] = valid_q[i] & we_q[i] & (dst_q[i] == src_a) & (src_a != '0);
      hit_b[i] = valid_q[i] & we_q[i] & (dst_q[i] == src_b) & (src_b != '0);
    end
  end

  assign hazard = hit_a[0] | hit_b[0];

endmodule

// File: tb/tb_dest_reg_pipe.sv
module tb_dest_reg_pipe;

  localparam int S = 3;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, reg_write, stall, flush;
  logic [1:0]   sel;
  logic [W-1:0] rt_addr, rd_addr, src_a, src_b;
  logic [W-1:0] out_dst;
  logic         out_we, hazard, sel_err;
  logic [S-1:0] hit_a, hit_b;

  dest_reg_pipe #(.ADDR_W(W), .STAGES(S), .LINK_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .reg_write(reg_write),
    .sel(sel), .rt_addr(rt_addr), .rd_addr(rd_addr), .stall(stall),
    .flush(flush), .src_a(src_a), .src_b(src_b), .out_dst(out_dst),
    .out_we(out_we), .hit_a(hit_a), .hit_b(hit_b), .hazard(hazard),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each captured instruction is an entry that ages by one on every advancing
  // edge and leaves once it has spent STAGES edges in flight.
  typedef struct {
    logic         v;
    logic         we;
    logic [W-1:0] dst;
    int           age;
  } ent_t;

  ent_t q[$];
  bit   m_sel_err = 1'b0;
  bit   dst_zero_known = 1'b0;  // last stage empty since reset: dst reads 0

  always @(posedge clk) begin
    logic [W-1:0] d;
    if (!rst_n) begin
      q.delete();
      m_sel_err      = 1'b0;
      dst_zero_known = 1'b1;
    end else if (flush) begin
      q.delete();
      dst_zero_known = 1'b0;
    end else if (!stall) begin
      d = (sel == 2'b00) ? rt_addr : (sel == 2'b01) ? rd_addr : W'(31);
      foreach (q[i]) q[i].age = q[i].age + 1;
      while (q.size() > 0 && q[0].age >= S) void'(q.pop_front());
      q.push_back('{v: in_valid, we: in_valid && reg_write && d != 0, dst: d, age: 0});
      m_sel_err = in_valid && sel == 2'b11;
    end
  end

  // Compare process: every falling edge once the DUT has seen a reset edge.
  always @(negedge clk) begin
    logic [S-1:0] ea, eb;
    logic         ewe, found;
    logic [W-1:0] edst;
    if (started) begin
      ea = '0; eb = '0; ewe = 1'b0; found = 1'b0; edst = '0;
      foreach (q[i]) begin
        if (q[i].v && q[i].we && q[i].dst == src_a && src_a != 0) ea[q[i].age] = 1'b1;
        if (q[i].v && q[i].we && q[i].dst == src_b && src_b != 0) eb[q[i].age] = 1'b1;
        if (q[i].age == S - 1) begin
          found = 1'b1;
          edst  = q[i].dst;
          ewe   = q[i].v && q[i].we;
        end
      end
      check("out_we", 32'(out_we), 32'(ewe));
      check("hit_a", 32'(hit_a), 32'(ea));
      check("hit_b", 32'(hit_b), 32'(eb));
      check("hazard", 32'(hazard), 32'(ea[0] | eb[0]));
      check("sel_err", 32'(sel_err), 32'(m_sel_err));
      if (found || dst_zero_known) check("out_dst", 32'(out_dst), 32'(edst));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    in_valid = 0; reg_write = 0; sel = 2'b00; rt_addr = 0; rd_addr = 0;
    stall = 0; flush = 0; src_a = 0; src_b = 0;
  endtask

  // Advance one edge; returns just after the following falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] s, input logic [W-1:0] a);
    idle();
    in_valid = 1; reg_write = 1; sel = s;
    if (s == 2'b00) rt_addr = a; else rd_addr = a;
  endtask

  logic [W-1:0] got[$];

  initial begin
    idle();
    rst_n = 0;
    @(posedge clk);
    started = 1'b1;
    tick();
    rst_n = 1;
    check("rst out_dst", 32'(out_dst), 0);
    check("rst out_we", 32'(out_we), 0);
    check("rst hit_a", 32'(hit_a), 0);
    check("rst hazard", 32'(hazard), 0);
    check("rst sel_err", 32'(sel_err), 0);

    // Single rd write: visible on the third edge counting the capture edge.
    wr(2'b01, 7); tick();
    idle(); tick();
    check("lat2 out_we", 32'(out_we), 0);
    tick();
    check("lat3 out_we", 32'(out_we), 1);
    check("lat3 out_dst", 32'(out_dst), 7);
    tick();
    check("lat4 out_we", 32'(out_we), 0);

    // JAL then a write to r0.
    wr(2'b10, 0); tick();
    wr(2'b00, 0); tick();
    idle(); tick();
    check("jal out_dst", 32'(out_dst), 31);
    check("jal out_we", 32'(out_we), 1);
    tick();
    check("r0 out_we", 32'(out_we), 0);
    tick();

    // Hazard walk: dst 9 moves through hit_a bits 0, 1, 2.
    wr(2'b00, 9); tick();
    idle(); src_a = 9; src_b = 3; #1;
    check("haz hit_a0", 32'(hit_a), 32'b001);
    check("haz hazard", 32'(hazard), 1);
    tick();
    check("haz hit_a1", 32'(hit_a), 32'b010);
    tick();
    check("haz hit_a2", 32'(hit_a), 32'b100);
    tick();
    check("haz hit_a3", 32'(hit_a), 32'b000);
    idle(); tick();

    // Stall with inputs ignored, then 5,6,7 delivered in order exactly once.
    got.delete();
    wr(2'b01, 5); tick();
    wr(2'b01, 6); tick();
    for (int i = 0; i < 2; i++) begin
      wr(2'b01, 7); stall = 1; tick();
      if (out_we) got.push_back(out_dst);
    end
    wr(2'b01, 7); tick();
    if (out_we) got.push_back(out_dst);
    for (int i = 0; i < 6; i++) begin
      idle(); tick();
      if (out_we) got.push_back(out_dst);
    end
    check("stall count", 32'(got.size()), 3);
    if (got.size() == 3) begin
      check("stall d0", 32'(got[0]), 5);
      check("stall d1", 32'(got[1]), 6);
      check("stall d2", 32'(got[2]), 7);
    end

    // Flush beats stall and in_valid.
    wr(2'b01, 12); tick();
    wr(2'b01, 13); tick();
    wr(2'b01, 14); stall = 1; flush = 1; src_a = 13; tick();
    check("flush hit_a", 32'(hit_a), 0);
    for (int i = 0; i < 3; i++) begin
      idle(); tick();
      check("flush out_we", 32'(out_we), 0);
    end

    // Illegal select, then reset mid-stream.
    wr(2'b11, 0); tick();
    check("selerr set", 32'(sel_err), 1);
    idle(); tick();
    check("selerr clr", 32'(sel_err), 0);
    tick();
    check("selerr out_dst", 32'(out_dst), 31);
    check("selerr out_we", 32'(out_we), 1);
    wr(2'b01, 20); tick();
    wr(2'b11, 21); src_b = 20; tick();
    rst_n = 0; stall = 1; flush = 1; tick();
    check("mrst out_dst", 32'(out_dst), 0);
    check("mrst out_we", 32'(out_we), 0);
    check("mrst hit_b", 32'(hit_b), 0);
    check("mrst sel_err", 32'(sel_err), 0);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      idle(); tick();
      check("mrst drain we", 32'(out_we), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
